// File: rtl/datapath_gen2_pkg.sv
// Shared select encodings for the gen2 datapath: accumulator, MDR, PC and ALU operand-2 sources.
package datapath_gen2_pkg;

  typedef enum logic [1:0] {
    AC_SRC_MAR = 2'b00,
    AC_SRC_MDR = 2'b01,
    AC_SRC_ALU = 2'b10,
    AC_SRC_IMM = 2'b11
  } ac_src_e;

  typedef enum logic [1:0] {
    MDR_SRC_ZERO = 2'b00,
    MDR_SRC_BUS  = 2'b01,
    MDR_SRC_IMM  = 2'b10,
    MDR_SRC_AC   = 2'b11
  } mdr_src_e;

  typedef enum logic [2:0] {
    PC_SRC_INC    = 3'b000,
    PC_SRC_IMM    = 3'b001,
    PC_SRC_AC     = 3'b010,
    PC_SRC_REL    = 3'b011,
    PC_SRC_CALL   = 3'b100,
    PC_SRC_RET    = 3'b101,
    PC_SRC_HOLD_A = 3'b110,
    PC_SRC_HOLD_B = 3'b111
  } pc_src_e;

  typedef enum logic [2:0] {
    OP2_ZERO = 3'd0,
    OP2_ONE  = 3'd1,
    OP2_TWO  = 3'd2,
    OP2_M1   = 3'd3,
    OP2_M2   = 3'd4,
    OP2_AC   = 3'd5,
    OP2_IMM  = 3'd6,
    OP2_MDR  = 3'd7
  } op2_sel_e;

endpackage

// File: rtl/datapath_gen2_if.sv
// Control/data bundle between the sequencer (master) and the gen2 datapath (slave).
interface datapath_gen2_if #(
  parameter int WIDTH       = 8,
  parameter int NACC        = 4,
  parameter int STACK_DEPTH = 8,
  parameter int FW          = 4
);
  logic [WIDTH-1:0]               immediate;
  logic [WIDTH-1:0]               mdr_in;
  logic [$clog2(NACC)-1:0]        ac_sel;
  logic [1:0]                     ac_source;
  logic                           write_ac;
  logic                           mar_source;
  logic                           write_mar;
  logic [1:0]                     mdr_source;
  logic                           write_mdr;
  logic                           write_flags;
  logic [2:0]                     pc_source;
  logic                           write_pc;
  logic                           stack_clr;
  logic [2:0]                     alu_op_select;
  logic [WIDTH-1:0]               alu_result;
  logic [FW-1:0]                  alu_flags;
  logic [WIDTH-1:0]               alu_op1;
  logic [WIDTH-1:0]               alu_op2;
  logic [WIDTH-1:0]               mar_out;
  logic [WIDTH-1:0]               mdr_out;
  logic [WIDTH-1:0]               pc_out;
  logic [FW-1:0]                  flags;
  logic [$clog2(STACK_DEPTH):0]   stack_depth;
  logic                           stack_err;

  modport master (
    output immediate, mdr_in, ac_sel, ac_source, write_ac, mar_source, write_mar,
           mdr_source, write_mdr, write_flags, pc_source, write_pc, stack_clr,
           alu_op_select, alu_result, alu_flags,
    input  alu_op1, alu_op2, mar_out, mdr_out, pc_out, flags, stack_depth, stack_err
  );

  modport slave (
    input  immediate, mdr_in, ac_sel, ac_source, write_ac, mar_source, write_mar,
           mdr_source, write_mdr, write_flags, pc_source, write_pc, stack_clr,
           alu_op_select, alu_result, alu_flags,
    output alu_op1, alu_op2, mar_out, mdr_out, pc_out, flags, stack_depth, stack_err
  );
endinterface

// File: rtl/datapath_gen2_ret_stack.sv
// LIFO return-address stack with sticky overflow/underflow error; clr outranks push/pop.
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        top,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    err
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SW-1:0]    sp;
  logic [SW-1:0]    sp_dec;

  assign full   = (sp == SW'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - SW'(1);
  assign top    = mem[sp_dec[PW-1:0]];
  assign depth  = sp;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (clr) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      if (push && !full)      sp <= sp + SW'(1);
      else if (pop && !empty) sp <= sp_dec;
      if ((push && full) || (pop && empty)) err <= 1'b1;
    end
  end

  // Entry storage carries no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[sp[PW-1:0]] <= din;
  end
endmodule

// File: rtl/datapath_gen2.sv
// Gen2 datapath: accumulator bank, MAR/MDR/PC/flags and operand muxes.
// Define DATAPATH_RET_STACK_EN to build the call/return stack.
module datapath_gen2
  import datapath_gen2_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NACC        = 4,
  parameter int STACK_DEPTH = 8,
  parameter int FW          = 4
) (
  input  logic           clk,
  input  logic           res,
  datapath_gen2_if.slave bus
);
  logic [WIDTH-1:0] acc [NACC];
  logic [WIDTH-1:0] mar_q, mdr_q, pc_q;
  logic [FW-1:0]    flags_q;
  logic [WIDTH-1:0] ac, pc_inc, pc_next, ac_wdata, mar_wdata, mdr_wdata, op2;

  assign ac     = acc[bus.ac_sel];
  assign pc_inc = pc_q + WIDTH'(1);

`ifdef DATAPATH_RET_STACK_EN
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top;

  assign stk_push = bus.write_pc && (pc_src_e'(bus.pc_source) == PC_SRC_CALL);
  assign stk_pop  = bus.write_pc && (pc_src_e'(bus.pc_source) == PC_SRC_RET);

  ret_stack #(.WIDTH(WIDTH), .DEPTH(STACK_DEPTH)) u_ret_stack (
    .clk   (clk),
    .res   (res),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (bus.stack_clr),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (bus.stack_depth),
    .err   (bus.stack_err)
  );
`else
  logic unused_stack_clr;
  assign unused_stack_clr = bus.stack_clr;
  assign bus.stack_depth  = '0;
  assign bus.stack_err    = 1'b0;
`endif

  always_comb begin
    case (op2_sel_e'(bus.alu_op_select))
      OP2_ZERO: op2 = '0;
      OP2_ONE:  op2 = WIDTH'(1);
      OP2_TWO:  op2 = WIDTH'(2);
      OP2_M1:   op2 = '1;
      OP2_M2:   op2 = {{(WIDTH-1){1'b1}}, 1'b0};
      OP2_AC:   op2 = ac;
      OP2_IMM:  op2 = bus.immediate;
      default:  op2 = mdr_q;
    endcase
  end

  always_comb begin
    case (ac_src_e'(bus.ac_source))
      AC_SRC_MAR: ac_wdata = mar_q;
      AC_SRC_MDR: ac_wdata = mdr_q;
      AC_SRC_ALU: ac_wdata = bus.alu_result;
      default:    ac_wdata = bus.immediate;
    endcase
    case (mdr_src_e'(bus.mdr_source))
      MDR_SRC_ZERO: mdr_wdata = '0;
      MDR_SRC_BUS:  mdr_wdata = bus.mdr_in;
      MDR_SRC_IMM:  mdr_wdata = bus.immediate;
      default:      mdr_wdata = ac;
    endcase
    mar_wdata = bus.mar_source ? bus.immediate : ac;
  end

  // A call into a full stack or a return from an empty one leaves the PC in place.
  always_comb begin
    case (pc_src_e'(bus.pc_source))
      PC_SRC_INC: pc_next = pc_inc;
      PC_SRC_IMM: pc_next = bus.immediate;
      PC_SRC_AC:  pc_next = ac;
      PC_SRC_REL: pc_next = pc_q + ac;
`ifdef DATAPATH_RET_STACK_EN
      PC_SRC_CALL: pc_next = stk_full  ? pc_q : bus.immediate;
      PC_SRC_RET:  pc_next = stk_empty ? pc_q : stk_top;
`else
      PC_SRC_CALL: pc_next = bus.immediate;
      PC_SRC_RET:  pc_next = pc_q;
`endif
      default:    pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      if (bus.write_ac)    acc[bus.ac_sel] <= ac_wdata;
      if (bus.write_mar)   mar_q   <= mar_wdata;
      if (bus.write_mdr)   mdr_q   <= mdr_wdata;
      if (bus.write_pc)    pc_q    <= pc_next;
      if (bus.write_flags) flags_q <= bus.alu_flags;
    end
  end

  assign bus.alu_op1 = ac;
  assign bus.alu_op2 = op2;
  assign bus.mar_out = mar_q;
  assign bus.mdr_out = mdr_q;
  assign bus.pc_out  = pc_q;
  assign bus.flags   = flags_q;
endmodule
